salu_issue_arbiter: RTL and testbench

//  Shares the single-cycle scalar ALU between NUM_REQ requesters (e.g. IQueue scalar path, branch unit).

---
 rtl/salu_issue_arbiter_if.sv | 38 +++
 rtl/salu_issue_arbiter.sv | 122 ++++++++++++
 tb/tb_salu_issue_arbiter.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/salu_issue_arbiter_if.sv
// Request and writeback bundle between the scalar-ALU issue arbiter and its clients.
interface salu_issue_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned TAG_W   = 4
);
  localparam int unsigned SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [6*NUM_REQ-1:0]     req_name;
  logic [32*NUM_REQ-1:0]    req_op1;
  logic [32*NUM_REQ-1:0]    req_op2;
  logic [32*NUM_REQ-1:0]    req_imm;
  logic [32*NUM_REQ-1:0]    req_pc;
  logic [NUM_REQ-1:0]       req_is_imm;
  logic [NUM_REQ-1:0]       req_is_pc;
  logic [TAG_W*NUM_REQ-1:0] req_tag;

  logic                     wb_valid;
  logic                     wb_ready;
  logic [31:0]              wb_val;
  logic [SRC_W-1:0]         wb_src;
  logic [TAG_W-1:0]         wb_tag;

  // Client side: drives requests, consumes results.
  modport master (
    output req_valid, req_name, req_op1, req_op2, req_imm, req_pc,
           req_is_imm, req_is_pc, req_tag, wb_ready,
    input  req_ready, wb_valid, wb_val, wb_src, wb_tag
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_name, req_op1, req_op2, req_imm, req_pc,
           req_is_imm, req_is_pc, req_tag, wb_ready,
    output req_ready, wb_valid, wb_val, wb_src, wb_tag
  );
endinterface

// File: rtl/salu_issue_arbiter.sv
// Round-robin issue arbiter for the shared single-cycle scalar ALU with a valid/ready writeback.
// Optional SALU_ARB_PERF_EN adds per-requester 32-bit grant counters on perf_grant_cnt.
module salu_issue_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned TAG_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  salu_issue_arbiter_if.slave   bus,
  output logic                  alu_issue_rdy,
  output logic                  alu_is_vec,
  output logic                  alu_is_imm,
  output logic                  alu_is_pc,
  output logic [5:0]            alu_name,
  output logic [31:0]           alu_op1,
  output logic [31:0]           alu_op2,
  output logic [31:0]           alu_imm,
  output logic [31:0]           alu_pc,
  input  logic [31:0]           alu_val
`ifdef SALU_ARB_PERF_EN
  ,
  output logic [32*NUM_REQ-1:0] perf_grant_cnt
`endif
);
  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [5:0]       name_a [NUM_REQ];
  logic [31:0]      op1_a  [NUM_REQ];
  logic [31:0]      op2_a  [NUM_REQ];
  logic [31:0]      imm_a  [NUM_REQ];
  logic [31:0]      pc_a   [NUM_REQ];
  logic [TAG_W-1:0] tag_a  [NUM_REQ];

  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   rr_next;
  logic [NUM_REQ-1:0] grant_vec;
  logic               grant_any;
  logic               can_issue;
  int unsigned        cand;

  logic               wb_valid_q;
  logic [IDX_W-1:0]   wb_src_q;
  logic [TAG_W-1:0]   wb_tag_q;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign name_a[g] = bus.req_name[6*g +: 6];
    assign op1_a[g]  = bus.req_op1[32*g +: 32];
    assign op2_a[g]  = bus.req_op2[32*g +: 32];
    assign imm_a[g]  = bus.req_imm[32*g +: 32];
    assign pc_a[g]   = bus.req_pc[32*g +: 32];
    assign tag_a[g]  = bus.req_tag[TAG_W*g +: TAG_W];
  end

  // First valid requester at or after the round-robin pointer, wrapping.
  always_comb begin
    can_issue = rdy & (~wb_valid_q | bus.wb_ready);
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = (32'(rr_ptr) + k) % NUM_REQ;
      if (can_issue && !grant_any && bus.req_valid[IDX_W'(cand)]) begin
        grant_any = 1'b1;
        grant_idx = IDX_W'(cand);
      end
    end
    grant_vec = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;
    rr_next   = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
  end

  assign bus.req_ready = grant_vec;
  assign alu_issue_rdy = |(bus.req_valid & grant_vec);
  assign alu_is_vec    = 1'b0;
  assign alu_is_imm    = bus.req_is_imm[grant_idx];
  assign alu_is_pc     = bus.req_is_pc[grant_idx];
  assign alu_name      = name_a[grant_idx];
  assign alu_op1       = op1_a[grant_idx];
  assign alu_op2       = op2_a[grant_idx];
  assign alu_imm       = imm_a[grant_idx];
  assign alu_pc        = pc_a[grant_idx];

  // In-flight op tracking; the ALU result arrives on alu_val the cycle after issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr     <= '0;
      wb_valid_q <= 1'b0;
      wb_src_q   <= '0;
      wb_tag_q   <= '0;
    end else if (rdy) begin
      if (grant_any) begin
        rr_ptr     <= rr_next;
        wb_valid_q <= 1'b1;
        wb_src_q   <= grant_idx;
        wb_tag_q   <= tag_a[grant_idx];
      end else if (bus.wb_ready) begin
        wb_valid_q <= 1'b0;
      end
    end
  end

  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_src   = wb_src_q;
  assign bus.wb_tag   = wb_tag_q;
  assign bus.wb_val   = alu_val;

`ifdef SALU_ARB_PERF_EN
  logic [31:0] grant_cnt [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        grant_cnt[g] <= '0;
      end else if (grant_any && (grant_idx == IDX_W'(g))) begin
        grant_cnt[g] <= grant_cnt[g] + 32'd1;
      end
    end
    assign perf_grant_cnt[32*g +: 32] = grant_cnt[g];
  end
`endif
endmodule

// File: tb/tb_salu_issue_arbiter.sv
// Self-checking bench for salu_issue_arbiter: behavioural arbitration model plus writeback scoreboard.
module tb_salu_issue_arbiter;
  localparam int unsigned N  = 2;
  localparam int unsigned TW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        alu_issue_rdy, alu_is_vec, alu_is_imm, alu_is_pc;
  logic [5:0]  alu_name;
  logic [31:0] alu_op1, alu_op2, alu_imm, alu_pc, alu_val;
`ifdef SALU_ARB_PERF_EN
  logic [32*N-1:0] perf_grant_cnt;
`endif

  always #5 clk = ~clk;

  salu_issue_arbiter_if #(.NUM_REQ(N), .TAG_W(TW)) bus ();

  salu_issue_arbiter #(.NUM_REQ(N), .TAG_W(TW)) dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .bus           (bus),
    .alu_issue_rdy (alu_issue_rdy),
    .alu_is_vec    (alu_is_vec),
    .alu_is_imm    (alu_is_imm),
    .alu_is_pc     (alu_is_pc),
    .alu_name      (alu_name),
    .alu_op1       (alu_op1),
    .alu_op2       (alu_op2),
    .alu_imm       (alu_imm),
    .alu_pc        (alu_pc),
    .alu_val       (alu_val)
`ifdef SALU_ARB_PERF_EN
    ,
    .perf_grant_cnt(perf_grant_cnt)
`endif
  );

  function automatic logic [31:0] alu_ref(input logic [5:0] nm, input logic [31:0] a, input logic [31:0] b);
    case (nm)
      6'd0:    return a + b;
      6'd1:    return a - b;
      6'd2:    return a ^ b;
      6'd3:    return a & b;
      default: return a | b;
    endcase
  endfunction

  // Registered ALU with synchronous reset, as seen by the arbiter.
  always_ff @(posedge clk) begin
    if (rst) alu_val <= '0;
    else if (alu_issue_rdy)
      alu_val <= alu_ref(alu_name, alu_is_pc ? alu_pc : alu_op1, alu_is_imm ? alu_imm : alu_op2);
  end

  typedef struct {
    logic [31:0]   val;
    int unsigned   src;
    logic [TW-1:0] tag;
  } wb_exp_t;

  wb_exp_t       sb[$];
  logic          p_v    [N];
  logic [5:0]    p_name [N];
  logic [31:0]   p_op1  [N];
  logic [31:0]   p_op2  [N];
  logic [31:0]   p_imm  [N];
  logic [31:0]   p_pc   [N];
  logic          p_ii   [N];
  logic          p_ip   [N];
  logic [TW-1:0] p_tag  [N];
  int unsigned   m_rr;
  int unsigned   m_cnt  [N];
  int            n_chk  = 0;
  int            n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
  endtask

  task automatic set_req(input int i, input logic v, input logic [5:0] nm,
                         input logic [31:0] o1, input logic [31:0] o2,
                         input logic [31:0] im, input logic [31:0] pc,
                         input logic ii, input logic ip, input logic [TW-1:0] tg);
    p_v[i] = v;  p_name[i] = nm; p_op1[i] = o1; p_op2[i] = o2;
    p_imm[i] = im; p_pc[i] = pc; p_ii[i] = ii; p_ip[i] = ip; p_tag[i] = tg;
    bus.req_valid[i +: 1]    = v;
    bus.req_name[6*i +: 6]   = nm;
    bus.req_op1[32*i +: 32]  = o1;
    bus.req_op2[32*i +: 32]  = o2;
    bus.req_imm[32*i +: 32]  = im;
    bus.req_pc[32*i +: 32]   = pc;
    bus.req_is_imm[i +: 1]   = ii;
    bus.req_is_pc[i +: 1]    = ip;
    bus.req_tag[TW*i +: TW]  = tg;
  endtask

  task automatic set_rand(input int i, input logic v);
    set_req(i, v, 6'($urandom_range(0, 4)), $urandom, $urandom, $urandom, $urandom,
            1'($urandom), 1'($urandom), TW'($urandom));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic model_clear();
    sb.delete();
    m_rr = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_clear();
    #1;
    chk("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
  endtask

  // Model of the arbiter: checks combinational outputs, then advances state for the coming edge.
  initial begin
    int          e;
    logic        can;
    int unsigned j;
    wb_exp_t     it;
    forever begin
      @(negedge clk);
      if (!rst) begin
        e   = -1;
        can = rdy && (sb.size() == 0 || bus.wb_ready);
        if (can) begin
          for (int k = 0; k < N; k++) begin
            j = (m_rr + 32'(k)) % N;
            if (e < 0 && p_v[j]) e = int'(j);
          end
        end
        chk("req_ready", 64'(bus.req_ready), (e >= 0) ? (64'd1 << e) : 64'd0);
        chk("alu_issue", 64'(alu_issue_rdy), 64'(e >= 0));
        chk("alu_is_vec", 64'(alu_is_vec), 64'd0);
        chk("wb_valid", 64'(bus.wb_valid), 64'(sb.size() > 0));
        if (sb.size() > 0) begin
          chk("wb_val", 64'(bus.wb_val), 64'(sb[0].val));
          chk("wb_src", 64'(bus.wb_src), 64'(sb[0].src));
          chk("wb_tag", 64'(bus.wb_tag), 64'(sb[0].tag));
        end
`ifdef SALU_ARB_PERF_EN
        for (int i = 0; i < N; i++) chk("perf_cnt", 64'(perf_grant_cnt[32*i +: 32]), 64'(m_cnt[i]));
`endif
        if (rdy) begin
          if (sb.size() > 0 && bus.wb_ready) void'(sb.pop_front());
          if (e >= 0) begin
            it.val = alu_ref(p_name[e], p_ip[e] ? p_pc[e] : p_op1[e], p_ii[e] ? p_imm[e] : p_op2[e]);
            it.src = 32'(e);
            it.tag = p_tag[e];
            sb.push_back(it);
            m_rr = (32'(e) + 1) % N;
            m_cnt[e]++;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    bus.wb_ready = 1'b1;
    model_clear();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0, '0);
    repeat (3) tick();
    at_neg();
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_issue", 64'(alu_issue_rdy), 64'd0);
    chk("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("rst_wb_src", 64'(bus.wb_src), 64'd0);
    chk("rst_wb_tag", 64'(bus.wb_tag), 64'd0);
    tick();
    rst = 1'b0;

    // Single ADD from requester 0.
    set_req(0, 1'b1, 6'd0, 32'd5, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, 4'd3);
    at_neg();
    chk("t1_grant", 64'(bus.req_ready), 64'b01);
    tick();
    set_req(0, 1'b0, 6'd0, 32'd5, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, 4'd3);
    at_neg();
    chk("t1_wb_valid", 64'(bus.wb_valid), 64'd1);
    chk("t1_wb_val", 64'(bus.wb_val), 64'd12);
    chk("t1_wb_src", 64'(bus.wb_src), 64'd0);
    tick();

    // Grant req1, then hold off writeback for three cycles.
    set_req(1, 1'b1, 6'd1, 32'd20, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0, 4'd9);
    at_neg();
    chk("bp_grant1", 64'(bus.req_ready), 64'b10);
    tick();
    bus.wb_ready = 1'b0;
    set_req(0, 1'b1, 6'd0, 32'd1, 32'd2, 32'd0, 32'd0, 1'b0, 1'b0, 4'd4);
    set_req(1, 1'b1, 6'd2, 32'd3, 32'd6, 32'd0, 32'd0, 1'b0, 1'b0, 4'd2);
    repeat (3) begin
      at_neg();
      chk("bp_no_grant", 64'(bus.req_ready), 64'd0);
      chk("bp_wb_val", 64'(bus.wb_val), 64'd15);
      chk("bp_wb_tag", 64'(bus.wb_tag), 64'd9);
      tick();
    end
    bus.wb_ready = 1'b1;
    at_neg();
    chk("bp_resume_req0", 64'(bus.req_ready), 64'b01);
    tick();

    // Asynchronous reset while a result is pending.
    set_req(0, 1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0, '0);
    set_req(1, 1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0, '0);
    rst_pulse();

    // Both requesters valid: strict alternation starting at req0.
    for (int k = 0; k < 6; k++) begin
      set_rand(0, 1'b1);
      set_rand(1, 1'b1);
      at_neg();
      chk("rr_seq", 64'(bus.req_ready), (k % 2 == 1) ? 64'b10 : 64'b01);
      tick();
    end

    // Freeze, then arbitration continues where it stopped.
    rdy = 1'b0;
    repeat (2) begin
      at_neg();
      chk("frz_req_ready", 64'(bus.req_ready), 64'd0);
      chk("frz_issue", 64'(alu_issue_rdy), 64'd0);
      chk("frz_wb_valid", 64'(bus.wb_valid), 64'd1);
      tick();
    end
    rdy = 1'b1;
    at_neg();
    chk("frz_resume", 64'(bus.req_ready), 64'b01);
    tick();

    // Random traffic with random freeze and backpressure.
    repeat (400) begin
      rdy = ($urandom % 8) != 0;
      bus.wb_ready = ($urandom % 4) != 0;
      for (int i = 0; i < N; i++) set_rand(i, 1'($urandom));
      tick();
    end

`ifdef SALU_ARB_PERF_EN
    rdy = 1'b1;
    bus.wb_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0, '0);
    tick();
    rst_pulse();
    tick();
    repeat (5) begin
      set_rand(0, 1'b1);
      tick();
    end
    set_req(0, 1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0, '0);
    repeat (3) begin
      set_rand(1, 1'b1);
      tick();
    end
    set_req(1, 1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0, '0);
    at_neg();
    chk("perf_total", perf_grant_cnt, {32'd3, 32'd5});
`endif

    for (int i = 0; i < N; i++) set_req(i, 1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0, '0);
    rdy = 1'b1;
    bus.wb_ready = 1'b1;
    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
